// File: rtl/core_pkg.sv
// Shared types for the LETC core pipeline: stage interface structs, ALU ops, RV32I opcodes.
package core_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, ALU_LINK
  } alu_op_e;

  localparam logic [6:0] OPCODE_LUI          = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC        = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL          = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR         = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH       = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD         = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE        = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM       = 7'b0010011;
  localparam logic [6:0] OPCODE_OP           = 7'b0110011;
  localparam logic [6:0] OPCODE_MISC_MEM     = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM       = 7'b1110011;
  localparam logic [6:0] OPCODE_CUSTOM0_EXIT = 7'b0001011;

  typedef struct packed {
    word_t pc;
    word_t instr;
    logic  valid;
  } s1_to_s2_s;

  typedef struct packed {
    logic  branch_en;
    word_t branch_target_addr;
  } s2_to_s1_s;

  typedef struct packed {
    logic       valid;
    word_t      pc;
    logic [4:0] rd_idx;
    word_t      rs1_val;
    word_t      rs2_val;
    word_t      imm;
    alu_op_e    alu_op;
    logic       is_load;
    logic       is_store;
    logic [2:0] funct3;
    logic       rd_we;
    logic       illegal;
  } s2_to_s3_s;

  localparam s2_to_s3_s S2_TO_S3_RESET = '{
    valid: 1'b0, pc: 32'hDEADBEEF, rd_idx: 5'd0, rs1_val: 32'hDEADBEEF,
    rs2_val: 32'hDEADBEEF, imm: 32'hDEADBEEF, alu_op: ALU_ADD, is_load: 1'b0,
    is_store: 1'b0, funct3: 3'd0, rd_we: 1'b0, illegal: 1'b0
  };

  // alt selects SUB/SRA (instr bit 30) where the encoding allows it
  function automatic alu_op_e arith_op(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/core_s2_decoder.sv
// Purely combinational RV32I + LETC.EXIT decoder: register indices, immediate, ALU op, class flags.
module core_s2_decoder
  import core_pkg::*;
(
  input  word_t      instr,
  output logic [4:0] rs1_idx,
  output logic [4:0] rs2_idx,
  output logic [4:0] rd_idx,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output word_t      imm,
  output alu_op_e    alu_op,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jal,
  output logic       is_jalr,
  output logic       is_auipc,
  output logic       is_exit,
  output logic       rd_we,
  output logic       illegal
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  word_t      imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];
  assign rd_idx  = instr[11:7];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    uses_rs1 = 1'b0; uses_rs2 = 1'b0; imm = '0; alu_op = ALU_ADD;
    is_load = 1'b0; is_store = 1'b0; is_branch = 1'b0; is_jal = 1'b0;
    is_jalr = 1'b0; is_auipc = 1'b0; is_exit = 1'b0; rd_we = 1'b0; illegal = 1'b0;
    case (opcode)
      OPCODE_LUI:   begin imm = imm_u; alu_op = ALU_LUI; rd_we = 1'b1; end
      OPCODE_AUIPC: begin imm = imm_u; alu_op = ALU_LUI; rd_we = 1'b1; is_auipc = 1'b1; end
      OPCODE_JAL:   begin imm = imm_j; alu_op = ALU_LINK; rd_we = 1'b1; is_jal = 1'b1; end
      OPCODE_JALR: begin
        imm = imm_i; alu_op = ALU_LINK; rd_we = 1'b1; uses_rs1 = 1'b1; is_jalr = 1'b1;
        illegal = (funct3 != 3'b000);
      end
      OPCODE_BRANCH: begin
        imm = imm_b; uses_rs1 = 1'b1; uses_rs2 = 1'b1; is_branch = 1'b1;
        illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPCODE_LOAD: begin
        imm = imm_i; uses_rs1 = 1'b1; rd_we = 1'b1; is_load = 1'b1;
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPCODE_STORE: begin
        imm = imm_s; uses_rs1 = 1'b1; uses_rs2 = 1'b1; is_store = 1'b1;
        illegal = (funct3 > 3'b010);
      end
      OPCODE_OP_IMM: begin
        imm = imm_i; uses_rs1 = 1'b1; rd_we = 1'b1;
        alu_op = arith_op(funct3, (funct3 == 3'b101) && instr[30]);
        illegal = ((funct3 == 3'b001) && (funct7 != 7'b0))
               || ((funct3 == 3'b101) && (funct7 != 7'b0) && (funct7 != 7'b0100000));
      end
      OPCODE_OP: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; rd_we = 1'b1;
        alu_op = arith_op(funct3, instr[30]);
        illegal = !((funct7 == 7'b0)
                 || ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPCODE_MISC_MEM: ;
      OPCODE_SYSTEM: illegal = !((instr == 32'h0000_0073) || (instr == 32'h0010_0073));
      OPCODE_CUSTOM0_EXIT: begin
        is_exit = (instr[31:7] == 25'b0);
        illegal = !is_exit;
      end
      default: illegal = 1'b1;
    endcase
    // an illegal word must not write back or trigger loads, stores or redirects
    if (illegal) begin
      rd_we = 1'b0; is_load = 1'b0; is_store = 1'b0; is_branch = 1'b0;
      is_jal = 1'b0; is_jalr = 1'b0; is_auipc = 1'b0;
    end
  end

endmodule

// File: rtl/core_s2.sv
// LETC decode stage: hazard/backpressure, branch resolution and redirect, halt flop, registered packet to s3.
module core_s2
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  s1_to_s2_s  s1_to_s2,
  output s2_to_s1_s  s2_to_s1,
  output logic       s2_busy,
  output logic       halt_req,
  input  logic       in_m_mode,
  input  logic       trap_occurred,
  output logic [4:0] rf_rs1_idx,
  output logic [4:0] rf_rs2_idx,
  input  word_t      rf_rs1_val,
  input  word_t      rf_rs2_val,
  input  logic       s3_load_pending,
  input  logic [4:0] s3_load_rd_idx,
  input  logic       s3_ready,
  output s2_to_s3_s  s2_to_s3
);

  logic [4:0] rd_idx;
  logic       uses_rs1, uses_rs2, is_load, is_store, is_branch, is_jal, is_jalr;
  logic       is_auipc, is_exit, rd_we, dec_illegal;
  word_t      imm;
  alu_op_e    alu_op;
  logic [2:0] funct3;

  core_s2_decoder u_decoder (
    .instr    (s1_to_s2.instr),
    .rs1_idx  (rf_rs1_idx),
    .rs2_idx  (rf_rs2_idx),
    .rd_idx   (rd_idx),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .imm      (imm),
    .alu_op   (alu_op),
    .is_load  (is_load),
    .is_store (is_store),
    .is_branch(is_branch),
    .is_jal   (is_jal),
    .is_jalr  (is_jalr),
    .is_auipc (is_auipc),
    .is_exit  (is_exit),
    .rd_we    (rd_we),
    .illegal  (dec_illegal)
  );

  assign funct3 = s1_to_s2.instr[14:12];

  logic load_use, accept, cond;

  assign load_use = s1_to_s2.valid && s3_load_pending && (s3_load_rd_idx != 5'd0)
                 && ((uses_rs1 && (rf_rs1_idx == s3_load_rd_idx))
                  || (uses_rs2 && (rf_rs2_idx == s3_load_rd_idx)));
  assign s2_busy  = s1_to_s2.valid && (load_use || (s2_to_s3.valid && !s3_ready));
  assign accept   = s1_to_s2.valid && !s2_busy && !trap_occurred;

  always_comb begin
    case (funct3)
      3'b000:  cond = (rf_rs1_val == rf_rs2_val);
      3'b001:  cond = (rf_rs1_val != rf_rs2_val);
      3'b100:  cond = ($signed(rf_rs1_val) <  $signed(rf_rs2_val));
      3'b101:  cond = ($signed(rf_rs1_val) >= $signed(rf_rs2_val));
      3'b110:  cond = (rf_rs1_val <  rf_rs2_val);
      3'b111:  cond = (rf_rs1_val >= rf_rs2_val);
      default: cond = 1'b0;
    endcase
  end

  assign s2_to_s1.branch_en          = accept && ((is_branch && cond) || is_jal || is_jalr);
  assign s2_to_s1.branch_target_addr = is_jalr ? ((rf_rs1_val + imm) & ~32'd1)
                                               : (s1_to_s2.pc + imm);

  // link value and AUIPC result are fully known here, so s3 just passes imm through
  s2_to_s3_s pkt_d;
  always_comb begin
    pkt_d         = S2_TO_S3_RESET;
    pkt_d.valid   = 1'b1;
    pkt_d.pc      = s1_to_s2.pc;
    pkt_d.rd_idx  = rd_idx;
    pkt_d.rs1_val = rf_rs1_val;
    pkt_d.rs2_val = rf_rs2_val;
    pkt_d.imm     = (is_jal || is_jalr) ? (s1_to_s2.pc + 32'd4)
                  : is_auipc            ? (s1_to_s2.pc + imm) : imm;
    pkt_d.alu_op  = alu_op;
    pkt_d.is_load = is_load;
    pkt_d.is_store= is_store;
    pkt_d.funct3  = funct3;
    pkt_d.rd_we   = rd_we;
    pkt_d.illegal = dec_illegal || (is_exit && !in_m_mode);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_to_s3 <= S2_TO_S3_RESET;
      halt_req <= 1'b0;
    end else begin
      if (trap_occurred)  s2_to_s3.valid <= 1'b0;
      else if (accept)    s2_to_s3       <= pkt_d;
      else if (s3_ready)  s2_to_s3.valid <= 1'b0;
      if (accept && is_exit && in_m_mode) halt_req <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_s2.sv
// Randomized self-checking bench for core_s2 against an instruction-level reference model.
module tb_core_s2;
  import core_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  s1_to_s2_s  s1_to_s2;
  s2_to_s1_s  s2_to_s1;
  logic       s2_busy, halt_req, in_m_mode, trap_occurred;
  logic [4:0] rf_rs1_idx, rf_rs2_idx, s3_load_rd_idx;
  word_t      rf_rs1_val, rf_rs2_val;
  logic       s3_load_pending, s3_ready;
  s2_to_s3_s  s2_to_s3;

  always #5 clk = ~clk;

  core_s2 dut (
    .clk(clk), .rst_n(rst_n), .s1_to_s2(s1_to_s2), .s2_to_s1(s2_to_s1),
    .s2_busy(s2_busy), .halt_req(halt_req), .in_m_mode(in_m_mode),
    .trap_occurred(trap_occurred), .rf_rs1_idx(rf_rs1_idx), .rf_rs2_idx(rf_rs2_idx),
    .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val), .s3_load_pending(s3_load_pending),
    .s3_load_rd_idx(s3_load_rd_idx), .s3_ready(s3_ready), .s2_to_s3(s2_to_s3)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef enum {K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LOAD, K_STORE,
                K_OPIMM, K_OP, K_EXIT, K_BAD} kind_e;
  typedef struct {
    kind_e      kind;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic       alt;
    word_t      imm;
  } tinstr_t;

  // reference model state
  logic      m_valid = 1'b0;
  logic      m_halt  = 1'b0;
  s2_to_s3_s m_pkt;

  function automatic tinstr_t mk(kind_e k, int rd, int rs1, int rs2, int f3, int alt, word_t imm);
    tinstr_t t;
    t.kind = k; t.rd = 5'(rd); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2);
    t.f3 = 3'(f3); t.alt = 1'(alt); t.imm = imm;
    return t;
  endfunction

  function automatic word_t encode(tinstr_t t);
    word_t i = t.imm;
    case (t.kind)
      K_LUI:   return {i[31:12], t.rd, 7'b0110111};
      K_AUIPC: return {i[31:12], t.rd, 7'b0010111};
      K_JAL:   return {i[20], i[10:1], i[11], i[19:12], t.rd, 7'b1101111};
      K_JALR:  return {i[11:0], t.rs1, 3'b000, t.rd, 7'b1100111};
      K_BR:    return {i[12], i[10:5], t.rs2, t.rs1, t.f3, i[4:1], i[11], 7'b1100011};
      K_LOAD:  return {i[11:0], t.rs1, t.f3, t.rd, 7'b0000011};
      K_STORE: return {i[11:5], t.rs2, t.rs1, t.f3, i[4:0], 7'b0100011};
      K_OPIMM: return {i[11:0], t.rs1, t.f3, t.rd, 7'b0010011};
      K_OP:    return {1'b0, t.alt, 5'b0, t.rs2, t.rs1, t.f3, t.rd, 7'b0110011};
      K_EXIT:  return 32'h0000_000B;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic tinstr_t rand_instr();
    tinstr_t t;
    word_t r = $urandom;
    logic [2:0] ld_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] br_f3[6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    t = mk(kind_e'($urandom_range(0, 10)), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1), $urandom);
    case (t.kind)
      K_LUI, K_AUIPC: t.imm = t.imm & 32'hFFFF_F000;
      K_JAL:  t.imm = {{11{r[20]}}, r[20:1], 1'b0};
      K_JALR: begin t.imm = {{20{r[11]}}, r[11:0]}; t.f3 = 3'd0; end
      K_LOAD: begin t.imm = {{20{r[11]}}, r[11:0]}; t.f3 = ld_f3[$urandom_range(0, 4)]; end
      K_STORE: begin t.imm = {{20{r[11]}}, r[11:0]}; t.f3 = 3'($urandom_range(0, 2)); end
      K_BR:   begin t.imm = {{19{r[12]}}, r[12:1], 1'b0}; t.f3 = br_f3[$urandom_range(0, 5)]; end
      K_OPIMM: begin
        if (t.f3 == 3'd1)      begin t.alt = 1'b0; t.imm = {27'b0, r[4:0]}; end
        else if (t.f3 == 3'd5) t.imm = {21'b0, t.alt, 5'b0, r[4:0]};
        else                   begin t.alt = 1'b0; t.imm = {{20{r[11]}}, r[11:0]}; end
      end
      K_OP: if (t.f3 != 3'd0 && t.f3 != 3'd5) t.alt = 1'b0;
      default: ;
    endcase
    return t;
  endfunction

  // expected packet and branch outcome from the instruction's mnemonic-level fields
  task automatic model_decode(input tinstr_t t, input word_t pc, r1, r2, input logic mm,
                              output s2_to_s3_s p, output logic u1, u2, tk, output word_t tgt);
    word_t w = encode(t);
    alu_op_e base[8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    p = '0;
    p.valid = 1'b1; p.pc = pc; p.rs1_val = r1; p.rs2_val = r2;
    p.rd_idx = w[11:7]; p.funct3 = w[14:12]; p.alu_op = ALU_ADD;
    u1 = t.kind inside {K_JALR, K_BR, K_LOAD, K_STORE, K_OPIMM, K_OP};
    u2 = t.kind inside {K_BR, K_STORE, K_OP};
    p.rd_we = t.kind inside {K_LUI, K_AUIPC, K_JAL, K_JALR, K_LOAD, K_OPIMM, K_OP};
    p.is_load = (t.kind == K_LOAD);
    p.is_store = (t.kind == K_STORE);
    p.imm = (t.kind inside {K_OP, K_EXIT, K_BAD}) ? 32'd0 : t.imm;
    tk = 1'b0;
    case (t.kind)
      K_LUI:   p.alu_op = ALU_LUI;
      K_AUIPC: begin p.alu_op = ALU_LUI; p.imm = pc + t.imm; end
      K_JAL, K_JALR: begin p.alu_op = ALU_LINK; p.imm = pc + 4; tk = 1'b1; end
      K_OPIMM, K_OP: begin
        p.alu_op = base[t.f3];
        if (t.alt && t.f3 == 3'd5) p.alu_op = ALU_SRA;
        if (t.alt && t.f3 == 3'd0) p.alu_op = ALU_SUB;
      end
      K_BR: case (t.f3)
        3'd0: tk = (r1 == r2);
        3'd1: tk = (r1 != r2);
        3'd4: tk = (int'(r1) <  int'(r2));
        3'd5: tk = (int'(r1) >= int'(r2));
        3'd6: tk = (r1 <  r2);
        default: tk = (r1 >= r2);
      endcase
      K_EXIT: p.illegal = !mm;
      K_BAD:  p.illegal = 1'b1;
      default: ;
    endcase
    tgt = (t.kind == K_JALR) ? ((r1 + t.imm) & ~32'd1) : (pc + t.imm);
  endtask

  // called at a falling edge; returns at the next falling edge
  task automatic run_cycle(input tinstr_t t, input logic v, input word_t pc, r1, r2,
                           input logic lp, input logic [4:0] lrd,
                           input logic rdy, tr, mm,
                           output logic acc, output logic tk_o, output word_t tgt_o);
    word_t w = encode(t);
    s2_to_s3_s p;
    logic u1, u2, tk, lu, busy;
    word_t tgt;
    s1_to_s2.pc = pc; s1_to_s2.instr = w; s1_to_s2.valid = v;
    rf_rs1_val = r1; rf_rs2_val = r2;
    s3_load_pending = lp; s3_load_rd_idx = lrd; s3_ready = rdy;
    trap_occurred = tr; in_m_mode = mm;
    model_decode(t, pc, r1, r2, mm, p, u1, u2, tk, tgt);
    lu   = v && lp && (lrd != 5'd0) && ((u1 && t.rs1 == lrd) || (u2 && t.rs2 == lrd));
    busy = v && (lu || (m_valid && !rdy));
    acc  = v && !busy && !tr;
    tk_o = acc && tk;
    tgt_o = tgt;
    #1;
    check("s2_busy", s2_busy, busy);
    check("branch_en", s2_to_s1.branch_en, tk_o);
    if (tk_o) check("branch_target", s2_to_s1.branch_target_addr, tgt);
    if (v && u1) check("rf_rs1_idx", rf_rs1_idx, w[19:15]);
    if (v && u2) check("rf_rs2_idx", rf_rs2_idx, w[24:20]);
    @(posedge clk);
    #1;
    if (tr) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1; m_pkt = p;
      if (t.kind == K_EXIT && mm) m_halt = 1'b1;
    end else if (rdy) m_valid = 1'b0;
    check("s3_valid", s2_to_s3.valid, m_valid);
    if (m_valid) check("s3_packet", s2_to_s3, m_pkt);
    check("halt_req", halt_req, m_halt);
    @(negedge clk);
  endtask

  initial begin
    s2_to_s3_s rp;
    tinstr_t   cur;
    logic      acc, tk, v, hold, lp, rdy, tr, mm;
    logic [4:0] lrd;
    word_t     tgt, pc, r1, r2;

    rst_n = 1'b0;
    s1_to_s2 = '0; rf_rs1_val = '0; rf_rs2_val = '0;
    s3_load_pending = 1'b0; s3_load_rd_idx = '0; s3_ready = 1'b1;
    trap_occurred = 1'b0; in_m_mode = 1'b0;
    repeat (2) @(negedge clk);
    rp = '0;
    rp.pc = 32'hDEADBEEF; rp.rs1_val = 32'hDEADBEEF; rp.rs2_val = 32'hDEADBEEF; rp.imm = 32'hDEADBEEF;
    check("reset_packet", s2_to_s3, rp);
    check("reset_halt", halt_req, 1'b0);
    check("reset_branch_en", s2_to_s1.branch_en, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADDI x1,x0,5 @0x100
    run_cycle(mk(K_OPIMM, 1, 0, 0, 0, 0, 5), 1, 32'h100, 0, 0, 0, 0, 1, 0, 1, acc, tk, tgt);
    check("addi_imm", s2_to_s3.imm, 32'd5);
    check("addi_rd", s2_to_s3.rd_idx, 5'd1);
    check("addi_alu", s2_to_s3.alu_op, ALU_ADD);
    check("addi_pc", s2_to_s3.pc, 32'h100);
    // BEQ x2,x3,+16 @0x200, equal then unequal operands
    run_cycle(mk(K_BR, 0, 2, 3, 0, 0, 16), 1, 32'h200, 32'h55, 32'h55, 0, 0, 1, 0, 1, acc, tk, tgt);
    run_cycle(mk(K_BR, 0, 2, 3, 0, 0, 16), 1, 32'h200, 32'h55, 32'h56, 0, 0, 1, 0, 1, acc, tk, tgt);
    // JALR x1,x5,3 with x5=0x1000
    run_cycle(mk(K_JALR, 1, 5, 0, 0, 0, 3), 1, 32'h300, 32'h1000, 0, 0, 0, 1, 0, 1, acc, tk, tgt);
    check("jalr_link", s2_to_s3.imm, 32'h304);
    check("jalr_rd_we", s2_to_s3.rd_we, 1'b1);
    // load-use on x7, then released
    run_cycle(mk(K_OP, 8, 7, 1, 0, 0, 0), 1, 32'h400, 1, 2, 1, 7, 1, 0, 1, acc, tk, tgt);
    run_cycle(mk(K_OP, 8, 7, 1, 0, 0, 0), 1, 32'h400, 1, 2, 0, 7, 1, 0, 1, acc, tk, tgt);
    check("load_use_release_rd", s2_to_s3.rd_idx, 5'd8);
    // trap beats a taken BNE
    run_cycle(mk(K_BR, 0, 2, 3, 1, 0, 8), 1, 32'h500, 1, 2, 0, 0, 1, 1, 1, acc, tk, tgt);
    check("trap_flush_valid", s2_to_s3.valid, 1'b0);
    // LETC.EXIT outside then inside M-mode
    run_cycle(mk(K_EXIT, 0, 0, 0, 0, 0, 0), 1, 32'h600, 0, 0, 0, 0, 1, 0, 0, acc, tk, tgt);
    check("exit_user_illegal", s2_to_s3.illegal, 1'b1);
    check("exit_user_no_halt", halt_req, 1'b0);
    run_cycle(mk(K_EXIT, 0, 0, 0, 0, 0, 0), 1, 32'h604, 0, 0, 0, 0, 1, 0, 1, acc, tk, tgt);
    run_cycle(mk(K_BAD, 0, 0, 0, 0, 0, 0), 0, 32'h608, 0, 0, 0, 0, 1, 0, 1, acc, tk, tgt);
    check("halt_sticky", halt_req, 1'b1);

    // asynchronous reset in the middle of operation
    run_cycle(mk(K_LUI, 3, 0, 0, 0, 0, 32'hABCDE000), 1, 32'h700, 0, 0, 0, 0, 0, 0, 1, acc, tk, tgt);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_valid", s2_to_s3.valid, 1'b0);
    check("midreset_halt", halt_req, 1'b0);
    check("midreset_pc", s2_to_s3.pc, 32'hDEADBEEF);
    m_valid = 1'b0; m_halt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    pc = $urandom & ~32'd3;
    hold = 1'b0; v = 1'b0; r1 = '0; r2 = '0; cur = rand_instr();
    for (int i = 0; i < 3000; i++) begin
      if (!hold) begin
        cur = rand_instr();
        v   = ($urandom_range(0, 9) != 0);
        r1  = $urandom;
        r2  = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      end
      lp  = ($urandom_range(0, 9) < 3);
      lrd = 5'($urandom_range(0, 7));
      rdy = ($urandom_range(0, 9) < 7);
      tr  = ($urandom_range(0, 99) < 8);
      mm  = ($urandom_range(0, 99) < 85);
      run_cycle(cur, v, pc, r1, r2, lp, lrd, rdy, tr, mm, acc, tk, tgt);
      hold = v && !acc;
      if (acc) pc = tk ? tgt : pc + 32'd4;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_s2.md
# core_s2

Decode stage of the LETC core, directly downstream of fetch (s1). Per instruction it:
- accepts the s1 instruction word and PC;
- decodes it, reads the register file and generates the immediate;
- resolves branches and jumps and returns the redirect to s1;
- raises the halt request on LETC.EXIT;
- registers the decoded packet toward s3.

It also produces the s1 backpressure signal (s2_busy) from load-use hazards and s3 backpressure.

## Interface
Parameters: none (widths from letc_pkg/core_pkg).
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- s1_to_s2  in  s1_to_s2_s  {pc, instr, valid} from fetch
- s2_to_s1  out  s2_to_s1_s  {branch_en, branch_target_addr} redirect to fetch
- s2_busy  out  1  s2 cannot accept a new instruction this cycle
- halt_req  out  1  LETC.EXIT accepted in M-mode
- in_m_mode  in  1  current privilege is M
- trap_occurred  in  1  trap redirect this cycle; flushes s2
- rf_rs1_idx, rf_rs2_idx  out  5  register file read addresses (combinational from instr)
- rf_rs1_val, rf_rs2_val  in  word_t  read data, same cycle
- s3_load_pending  in  1  s3 holds a valid load
- s3_load_rd_idx  in  5  that load's rd
- s3_ready  in  1  s3 accepts s2_to_s3 this cycle
- s2_to_s3  out  s2_to_s3_s  {valid, pc, rd_idx, rs1_val, rs2_val, imm, alu_op, is_load, is_store, funct3, rd_we, illegal}

## Operation
- Decode RV32I base opcodes, plus LETC.EXIT = opcode 0001011, funct3 000, all other bits zero. Anything else → illegal=1, rd_we=0.
- Immediate generation: I/S/B/U/J formats, sign-extended to 32 bits.
- load_use: valid && s3_load_pending && s3_load_rd_idx!=0 && (rs1 or rs2 used) && equal to s3_load_rd_idx.
- s2_busy = s1_to_s2.valid && (load_use || (s2_to_s3.valid && !s3_ready)).
- accept = s1_to_s2.valid && !s2_busy && !trap_occurred.
- Branch resolution, combinational, only when accept:
  - BEQ/BNE: 32-bit compare.
  - BLT/BGE: signed compare.
  - BLTU/BGEU: unsigned compare.
  - JAL: always taken, target pc+imm.
  - JALR: always taken, target (rs1+imm) & ~1.
  - Branch target: pc+imm, modulo 2^32.
  - branch_en=1 only if taken.
- JAL/JALR: rd_we=1; the link value (pc+4) is carried as imm with alu_op=LINK.
- Output register:
  - if trap_occurred: valid←0;
  - else if accept: load the packet, valid←1;
  - else if s3_ready: valid←0;
  - else hold.
- halt_req: a flop set when accept of LETC.EXIT with in_m_mode=1; sticky until reset. EXIT outside M-mode is illegal.

## Timing
- Reset values:
  - s2_to_s3.valid=0; pc/imm/rs*_val=32'hDEADBEEF; others 0.
  - halt_req=0.
  - branch_en=0 (combinational, valid=0 path).
- Latency: instruction accepted at edge N appears on s2_to_s3 after edge N (one cycle).
- branch_en is combinational in the accept cycle. The branch instruction itself is still forwarded to s3 that edge. The next instruction presented by s1 is at the target.
- branch_en is never asserted while s2_busy=1, so a redirect never coincides with a stall.
- trap_occurred and a valid branch in the same cycle: trap wins; branch_en=0; nothing accepted.
- A stall holds the s1 instruction; decode outputs and rf indices stay stable.
- Reset mid-operation clears valid and halt_req asynchronously.

## Structure
- core_pkg holds:
  - s2_to_s3_s and alu_op_e (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI, LINK);
  - opcode localparams (incl. OPCODE_CUSTOM0_EXIT);
  - the extended s2_to_s1_s.
- Sub-module core_s2_decoder: purely combinational instr → {rs1/rs2/rd idx, uses_rs1/2, imm, alu_op, class flags, illegal}.
- core_s2 keeps the hazard logic, branch compare, output flops and halt flop.

## Test plan
- ADDI x1,x0,5 @pc 0x100, s3_ready=1 → next cycle s2_to_s3.valid=1, imm=5, rd_idx=1, alu_op=ADD, pc=0x100.
- BEQ x2,x3,+16 @0x200, rf vals equal → branch_en=1, target 0x210 same cycle. Vals unequal → branch_en=0.
- JALR x1,x5,3 with x5=0x1000 → target 0x1002, rd_we=1, imm=0x(pc+4).
- s3 load to x7 pending, s2 holds ADD x8,x7,x1 → s2_busy=1, no accept. With s3_load_pending=0 → accepted next cycle.
- trap_occurred with a valid BNE taken → branch_en=0, s2_to_s3.valid=0 after edge.
- LETC.EXIT (0x0000000B) with in_m_mode=1 → halt_req=1 next cycle and stays 1. With in_m_mode=0 → illegal=1, halt_req stays 0.
